write_fifo_core: RTL and testbench

Serialises a 3072-bit result vector into 96 32-bit words and buffers them in an on-chip synchronous FIFO for word-wide readout. It sits at the output of the result datapath: the upstream stage presents `final_result` and pulses or holds `write_en`; a downstream consumer drains words with `rd_en`.

---
 rtl/write_fifo_core.sv | 95 +++++++++
 tb/tb_write_fifo_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/write_fifo_core.sv
// Serialises a RESULT_W-bit result vector into WORD_W-bit words, LSW first,
// and buffers them in a synchronous circular FIFO for word-wide readout.
module write_fifo_core #(
  parameter int RESULT_W = 3072,
  parameter int WORD_W   = 32,
  parameter int NWORDS   = RESULT_W / WORD_W,
  parameter int DEPTH    = 128
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                write_en,
  input  logic [RESULT_W-1:0] final_result,
  input  logic                rd_en,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic [WORD_W-1:0]   read_data
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, PUSH} state_t;

  state_t              state, state_nxt;
  logic [RESULT_W-1:0] frame;
  logic [IDX_W-1:0]    idx;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   push_word;
  logic                push, pop, last_word, capture;

  // Push is gated by the registered count only, so a simultaneous pop
  // never lets a word in while the FIFO is full.
  always_comb begin
    capture   = (state == IDLE) && write_en;
    push      = (state == PUSH) && (count != CNT_W'(DEPTH));
    pop       = rd_en && (count != '0);
    last_word = (idx == IDX_W'(NWORDS - 1));
    push_word = frame[idx*WORD_W +: WORD_W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (write_en) state_nxt = PUSH;
      PUSH:    if (push && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (capture) frame <= final_result;
  end

  always_ff @(posedge clk_in) begin
    if (rst)          idx <= '0;
    else if (capture) idx <= '0;
    else if (push)    idx <= idx + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      read_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);

endmodule

// File: tb/tb_write_fifo_core.sv
// Bench for write_fifo_core: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_write_fifo_core;

  localparam int RESULT_W = 3072;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = RESULT_W / WORD_W;
  localparam int DEPTH    = 128;

  logic                clk_in = 1'b0;
  logic                rst = 1'b1;
  logic                write_en = 1'b0;
  logic [RESULT_W-1:0] final_result = '0;
  logic                rd_en = 1'b0;
  logic                fifo_full, fifo_empty;
  logic [WORD_W-1:0]   read_data;

  write_fifo_core #(
    .RESULT_W(RESULT_W),
    .WORD_W  (WORD_W),
    .NWORDS  (NWORDS),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .write_en    (write_en),
    .final_result(final_result),
    .rd_en       (rd_en),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .read_data   (read_data)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nvec = 0;
  int nmis = 0;

  // Behavioural model: FIFO contents as a queue, the pending frame as an
  // array slice plus the number of words already enqueued from it.
  logic [WORD_W-1:0]   m_q[$];
  logic [RESULT_W-1:0] m_frame;
  int                  m_next = 0;
  bit                  m_busy = 0;
  logic [WORD_W-1:0]   m_data = '0;

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic rd,
                            input logic [RESULT_W-1:0] fr);
    int sz;
    if (r) begin
      m_q.delete();
      m_busy = 0;
      m_next = 0;
      m_data = '0;
    end else begin
      sz = m_q.size();
      if (rd && sz > 0) m_data = m_q.pop_front();
      if (m_busy) begin
        if (sz < DEPTH) begin
          m_q.push_back(m_frame[m_next*WORD_W +: WORD_W]);
          m_next++;
          if (m_next == NWORDS) m_busy = 0;
        end
      end else if (w) begin
        m_frame = fr;
        m_next  = 0;
        m_busy  = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [RESULT_W-1:0] fr);
    rst = r; write_en = w; rd_en = rd; final_result = fr;
    @(posedge clk_in);
    model_edge(r, w, rd, fr);
    #1;
    check("model_empty", WORD_W'(fifo_empty), WORD_W'(m_q.size() == 0));
    check("model_full",  WORD_W'(fifo_full),  WORD_W'(m_q.size() == DEPTH));
    check("model_data",  read_data, m_data);
  endtask

  function automatic logic [RESULT_W-1:0] rand_frame();
    logic [RESULT_W-1:0] f;
    for (int unsigned i = 0; i < NWORDS; i++) f[i*WORD_W +: WORD_W] = $urandom;
    return f;
  endfunction

  typedef struct {
    logic        r, w, rd;
    logic [31:0] w0;
    int          n;
    logic        e_empty, e_full;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[8];

  logic [RESULT_W-1:0] fa, fb, fr;

  initial begin
    // reset, pop on empty, single frame of 0x2AAAAAAA then zeros, drain
    vecs[0] = '{1, 0, 0, 32'h0,        2,  1, 0, 32'h0};
    vecs[1] = '{0, 0, 1, 32'h0,        1,  1, 0, 32'h0};
    vecs[2] = '{0, 1, 0, 32'h2AAAAAAA, 1,  1, 0, 32'h0};
    vecs[3] = '{0, 0, 0, 32'h0,        1,  0, 0, 32'h0};
    vecs[4] = '{0, 0, 0, 32'h0,        95, 0, 0, 32'h0};
    vecs[5] = '{0, 0, 1, 32'h0,        1,  0, 0, 32'h2AAAAAAA};
    vecs[6] = '{0, 0, 1, 32'h0,        95, 1, 0, 32'h0};
    vecs[7] = '{0, 0, 1, 32'h0,        1,  1, 0, 32'h0};

    foreach (vecs[k]) begin
      fr = '0;
      fr[31:0] = vecs[k].w0;
      for (int i = 0; i < vecs[k].n; i++) step(vecs[k].r, vecs[k].w, vecs[k].rd, fr);
      check($sformatf("vec%0d_empty", k), WORD_W'(fifo_empty), WORD_W'(vecs[k].e_empty));
      check($sformatf("vec%0d_full", k),  WORD_W'(fifo_full),  WORD_W'(vecs[k].e_full));
      check($sformatf("vec%0d_data", k),  read_data, vecs[k].e_data);
    end

    // word ordering: word i carries i+1
    for (int unsigned i = 0; i < NWORDS; i++) fa[i*WORD_W +: WORD_W] = i + 1;
    step(0, 1, 0, fa);
    for (int i = 0; i < NWORDS; i++) step(0, 0, 0, '0);
    for (int i = 0; i < NWORDS; i++) begin
      step(0, 0, 1, '0);
      check("order", read_data, WORD_W'(i + 1));
    end
    check("order_empty", WORD_W'(fifo_empty), 32'd1);

    // fill to full with write_en held; second frame stalls at word 32
    step(1, 0, 0, '0);
    fa = rand_frame();
    fb = rand_frame();
    step(0, 1, 0, fa);
    for (int k = 1; k <= 128; k++) step(0, 1, 0, fb);
    check("full_c128", WORD_W'(fifo_full), 32'd0);
    step(0, 1, 0, fb);
    check("full_c129", WORD_W'(fifo_full), 32'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0);
    check("full_stall", WORD_W'(fifo_full), 32'd1);
    step(0, 0, 1, '0);
    check("stall_pop_data", read_data, fa[31:0]);
    check("stall_pop_full", WORD_W'(fifo_full), 32'd0);
    step(0, 0, 0, '0);
    check("stall_refill", WORD_W'(fifo_full), 32'd1);
    for (int k = 1; k < NWORDS; k++) begin
      step(0, 0, 1, '0);
      check("drain_f0", read_data, fa[k*WORD_W +: WORD_W]);
    end
    for (int k = 0; k < NWORDS; k++) begin
      step(0, 0, 1, '0);
      check("drain_f1", read_data, fb[k*WORD_W +: WORD_W]);
    end
    check("drain_empty", WORD_W'(fifo_empty), 32'd1);

    // reset in the middle of PUSH, then a clean frame
    fa = rand_frame();
    step(0, 1, 0, fa);
    for (int k = 1; k < 40; k++) step(0, 0, k[0], '0);
    step(1, 0, 0, '0);
    check("midrst_empty", WORD_W'(fifo_empty), 32'd1);
    check("midrst_full",  WORD_W'(fifo_full),  32'd0);
    check("midrst_data",  read_data, 32'd0);
    for (int unsigned i = 0; i < NWORDS; i++) fb[i*WORD_W +: WORD_W] = 32'hC000_0000 + i;
    step(0, 1, 0, fb);
    for (int i = 0; i < NWORDS; i++) step(0, 0, 0, '0);
    for (int unsigned i = 0; i < NWORDS; i++) begin
      step(0, 0, 1, '0);
      check("midrst_order", read_data, 32'hC000_0000 + i);
    end

    // randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) < 55), rand_frame());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
